pong_graph_animate: RTL
=======================

// Module: pong_graph_animate
// PURPOSE
//  Pixel generator and object animator fed by vga_synch (x_pixel, y_pixel, video_on, pixel_tick).
//  Holds the left wall, the right paddle and the ball, and moves them once per frame.
//  Produces 3-bit RGB for the DAC/VGA pins, plus hit/miss pulses for the score/text logic.
// PARAMETERS
//  WALL_X_L     32   wall left column
//  WALL_X_R     35   wall right column
//  BAR_X_L      600  paddle left column
//  BAR_X_R      603  paddle right column
//  BAR_Y_SIZE   72   paddle height, pixels
//  BAR_V        4    paddle step per frame
//  BALL_SIZE    8    ball edge, pixels
//  BALL_V       2    ball speed magnitude per axis per frame
//  MISS_FRAMES  60   frames spent in MISS before returning to IDLE
// PORTS
//  clk         in   1   system clock (2x pixel clock)
//  reset       in   1   asynchronous, active-low reset
//  pixel_tick  in   1   pixel enable from vga_synch
//  video_on    in   1   visible-area flag from vga_synch
//  x_pixel     in   10  current column
//  y_pixel     in   10  current row
//  btn_up      in   1   paddle up, level, already debounced
//  btn_down    in   1   paddle down, level, already debounced
//  serve       in   1   level; launches the ball from IDLE
//  rgb         out  3   {R,G,B}, registered
//  hit         out  1   one-clk pulse: ball reflected by paddle
//  miss        out  1   one-clk pulse: ball passed paddle
// BEHAVIOUR
//  Frame tick
//  - refr_tick = pixel_tick & (y_pixel==481) & (x_pixel==0).
//  - Exactly one clk high per frame. All motion updates only on refr_tick.
//  Reset (reset=0, async)
//  - bar_y_t=204, ball_x=316, ball_y=236, dx=+BALL_V, dy=+BALL_V.
//  - state=IDLE, miss_cnt=0, rgb=0, hit=0, miss=0.
//  - Reset mid-frame or mid-play is immediate and complete.
//  Paddle, on refr_tick
//  - btn_down & !btn_up & (bar_y_t+BAR_Y_SIZE-1 < 479-BAR_V): bar_y_t += BAR_V.
//  - btn_up & !btn_down & (bar_y_t > BAR_V): bar_y_t -= BAR_V.
//  - Both buttons pressed, or the limit is reached: paddle holds.
//  - The paddle also moves in IDLE and MISS.
//  Ball FSM, states IDLE / PLAY / MISS
//  - IDLE: ball hidden; position held at 316,236.
//    serve=1 on refr_tick -> PLAY with dx=+BALL_V, dy=+BALL_V.
//  - PLAY, each refr_tick: compute the new deltas from the current position, then
//    pos += new delta (10-bit two's-complement add; bounds guarantee no wrap).
//    - ball_y <= BALL_V: dy=+BALL_V.
//    - ball_y+BALL_SIZE-1 >= 479-BALL_V: dy=-BALL_V.
//    - ball_x <= WALL_X_R+1: dx=+BALL_V.
//    - Paddle hit when all hold: ball_x+BALL_SIZE-1 in [BAR_X_L,BAR_X_R], dx>0, and the
//      ball's y range overlaps the paddle. Then dx=-BALL_V and hit=1 for that clk.
//    - Horizontal and vertical reflections in the same frame both apply (corner bounce).
//    - ball_x > BAR_X_R with dx>0: miss=1 for that clk, -> MISS. No motion that frame.
//  - MISS: ball hidden. miss_cnt increments per refr_tick.
//    At MISS_FRAMES-1: clear the counter, reset the ball position, -> IDLE. serve is ignored.
//  Pixel path
//  - rgb registered; it reflects the x/y/video_on of the previous clk (latency 1 clk).
//  - video_on=0 gives rgb=000.
//  - Priority: wall 001 > paddle 010 > ball 100 (PLAY only) > background 000.
// CONFIGURATION
//  PONG_ROUND_BALL_EN
//  - Defined: the ball pixel is additionally gated by an 8x8 circle ROM (rows
//    3C,7E,FF,FF,FF,FF,7E,3C), indexed by x_pixel-ball_x and y_pixel-ball_y.
//    BALL_SIZE must be 8.
//  - Undefined: the ball is a solid BALL_SIZE square. Motion and collision are identical
//    in both builds (square bounding box).
// TESTING
//  1. reset=0 mid-frame with the ball moving
//     -> next clk: rgb=0, state IDLE, ball 316,236, bar_y_t=204.
//  2. btn_down held 200 frames
//     -> bar_y_t climbs by 4/frame and stops at 404 (bottom 475). Both buttons held -> no move.
//  3. serve, then no paddle input
//     -> ball at 318,238 after frame 1; dy flips to -2 when ball_y+7 >= 477.
//  4. Paddle aligned with the ball path
//     -> exactly one hit pulse, dx=-2 next frame, ball reflects off the wall at x<=36.
//  5. Paddle parked away from the ball path
//     -> one miss pulse, ball hidden, IDLE after 60 frames, serve relaunches.
//  6. Pixel probe at x=33 / x=601 (paddle row) / inside the ball
//     -> rgb 001 / 010 / 100. Ball corner pixel is 000 when PONG_ROUND_BALL_EN is defined.

Source files
------------

// File: rtl/pong_graph_animate.sv
// pong_graph_animate
//   Pixel generator and object animator for a single-player pong screen.
//   Draws the left wall, the right paddle and the ball. Moves the paddle and
//   the ball once per frame, and pulses hit/miss for the score logic.
//
// Ports
//   clk         system clock (2x pixel clock)
//   reset       asynchronous, active-low reset
//   pixel_tick  pixel enable from the sync generator
//   video_on    visible-area flag
//   x_pixel     current column (10 bit)
//   y_pixel     current row (10 bit)
//   btn_up      paddle up, debounced level
//   btn_down    paddle down, debounced level
//   serve       level; launches the ball from IDLE
//   rgb         {R,G,B}, registered, one clk behind x/y/video_on
//   hit         one-clk pulse when the paddle reflects the ball
//   miss        one-clk pulse when the ball passes the paddle
//
// Build option
//   PONG_ROUND_BALL_EN  when defined, the ball is drawn through an 8x8 circle
//                       mask (BALL_SIZE must be 8). Motion and collision still
//                       use the square bounding box.
//
// Ball FSM
//   state | meaning
//   IDLE  | ball hidden, parked at 316,236, waiting for serve
//   PLAY  | ball visible and moving, bounces off walls/paddle
//   MISS  | ball hidden, counting MISS_FRAMES frames before IDLE
module pong_graph_animate #(
  parameter int WALL_X_L    = 32,
  parameter int WALL_X_R    = 35,
  parameter int BAR_X_L     = 600,
  parameter int BAR_X_R     = 603,
  parameter int BAR_Y_SIZE  = 72,
  parameter int BAR_V       = 4,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_V      = 2,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       serve,
  output logic [2:0] rgb,
  output logic       hit,
  output logic       miss
);

  localparam logic [9:0] WXL          = 10'(WALL_X_L);
  localparam logic [9:0] WXR          = 10'(WALL_X_R);
  localparam logic [9:0] WALL_LIM     = 10'(WALL_X_R + 1);
  localparam logic [9:0] BXL          = 10'(BAR_X_L);
  localparam logic [9:0] BXR          = 10'(BAR_X_R);
  localparam logic [9:0] BAR_H_M1     = 10'(BAR_Y_SIZE - 1);
  localparam logic [9:0] BAR_STEP     = 10'(BAR_V);
  localparam logic [9:0] BAR_BOT_LIM  = 10'(479 - BAR_V);
  localparam logic [9:0] BALL_M1      = 10'(BALL_SIZE - 1);
  localparam logic [9:0] BALL_POS_V   = 10'(BALL_V);
  localparam logic [9:0] BALL_NEG_V   = 10'(-BALL_V);
  localparam logic [9:0] BALL_BOT_LIM = 10'(479 - BALL_V);
  localparam logic [9:0] BAR_Y_RST    = 10'd204;
  localparam logic [9:0] BALL_X_RST   = 10'd316;
  localparam logic [9:0] BALL_Y_RST   = 10'd236;
  localparam int         MCW          = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

  state_t         state;
  logic [9:0]     bar_y_t, ball_x, ball_y, dx, dy;
  logic [MCW-1:0] miss_cnt;

  logic       refr_tick;
  logic [9:0] dx_n, dy_n;
  logic       hit_c, miss_c, ball_y_ovl;

  assign refr_tick = pixel_tick && (y_pixel == 10'd481) && (x_pixel == 10'd0);

  // New deltas are derived from the current position and the current paddle
  // position; dx is always +/-BALL_V so its sign bit alone tells direction.
  always_comb begin
    dx_n       = dx;
    dy_n       = dy;
    hit_c      = 1'b0;
    miss_c     = 1'b0;
    ball_y_ovl = ((ball_y + BALL_M1) >= bar_y_t) && (ball_y <= (bar_y_t + BAR_H_M1));
    if (ball_y <= BALL_POS_V)
      dy_n = BALL_POS_V;
    else if ((ball_y + BALL_M1) >= BALL_BOT_LIM)
      dy_n = BALL_NEG_V;
    if (!dx[9] && (ball_x > BXR)) begin
      miss_c = 1'b1;
    end else if (ball_x <= WALL_LIM) begin
      dx_n = BALL_POS_V;
    end else if (!dx[9] && ((ball_x + BALL_M1) >= BXL) &&
                 ((ball_x + BALL_M1) <= BXR) && ball_y_ovl) begin
      dx_n  = BALL_NEG_V;
      hit_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bar_y_t  <= BAR_Y_RST;
      ball_x   <= BALL_X_RST;
      ball_y   <= BALL_Y_RST;
      dx       <= BALL_POS_V;
      dy       <= BALL_POS_V;
      miss_cnt <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (refr_tick) begin
        // paddle runs in every state
        if (btn_down && !btn_up && ((bar_y_t + BAR_H_M1) < BAR_BOT_LIM))
          bar_y_t <= bar_y_t + BAR_STEP;
        else if (btn_up && !btn_down && (bar_y_t > BAR_STEP))
          bar_y_t <= bar_y_t - BAR_STEP;

        case (state)
          IDLE: begin
            if (serve) begin
              state <= PLAY;
              dx    <= BALL_POS_V;
              dy    <= BALL_POS_V;
            end
          end
          PLAY: begin
            if (miss_c) begin
              miss  <= 1'b1;
              state <= MISS;
            end else begin
              dx     <= dx_n;
              dy     <= dy_n;
              ball_x <= ball_x + dx_n;
              ball_y <= ball_y + dy_n;
              hit    <= hit_c;
            end
          end
          MISS: begin
            if (miss_cnt == MISS_LAST) begin
              miss_cnt <= '0;
              ball_x   <= BALL_X_RST;
              ball_y   <= BALL_Y_RST;
              state    <= IDLE;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic       wall_on, bar_on, ball_sq_on, ball_on;
  logic [2:0] rgb_n;
`ifdef PONG_ROUND_BALL_EN
  logic [2:0] rom_row, rom_col;
  logic [7:0] rom_bits;
`endif

  always_comb begin
    wall_on    = (x_pixel >= WXL) && (x_pixel <= WXR);
    bar_on     = (x_pixel >= BXL) && (x_pixel <= BXR) &&
                 (y_pixel >= bar_y_t) && (y_pixel <= (bar_y_t + BAR_H_M1));
    ball_sq_on = (state == PLAY) &&
                 (x_pixel >= ball_x) && (x_pixel <= (ball_x + BALL_M1)) &&
                 (y_pixel >= ball_y) && (y_pixel <= (ball_y + BALL_M1));
`ifdef PONG_ROUND_BALL_EN
    // low three bits of the offset inside the 8x8 box address the mask
    rom_row = y_pixel[2:0] - ball_y[2:0];
    rom_col = x_pixel[2:0] - ball_x[2:0];
    case (rom_row)
      3'd0:    rom_bits = 8'h3C;
      3'd1:    rom_bits = 8'h7E;
      3'd6:    rom_bits = 8'h7E;
      3'd7:    rom_bits = 8'h3C;
      default: rom_bits = 8'hFF;
    endcase
    ball_on = ball_sq_on && rom_bits[3'd7 - rom_col];
`else
    ball_on = ball_sq_on;
`endif
    if (!video_on)    rgb_n = 3'b000;
    else if (wall_on) rgb_n = 3'b001;
    else if (bar_on)  rgb_n = 3'b010;
    else if (ball_on) rgb_n = 3'b100;
    else              rgb_n = 3'b000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb <= 3'b000;
    else        rgb <= rgb_n;
  end

endmodule
